// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared types and register addresses for the LED blink controller
package blink_pkg;

  typedef enum logic [1:0] {
    DISABLED  = 2'd0,
    ON_PHASE  = 2'd1,
    OFF_PHASE = 2'd2
  } blink_state_t;

  localparam logic [4:0] ADDR_CTRL        = 5'h00;
  localparam logic [4:0] ADDR_PERIOD_BASE = 5'h01;
  localparam logic [4:0] ADDR_SYNC        = 5'h1F;

endpackage

// File: rtl/blink_channel.sv
// rtl/blink_channel.sv - per-LED phase FSM with a restartable half-period counter
module blink_channel
  import blink_pkg::*;
#(
  parameter int N = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] period,
  input  logic         restart,
  output logic         led
);

  blink_state_t state_q;
  logic [N-1:0] cnt_q;
  logic         led_q;
  logic         last_cycle;

  // Full-width compare so the counter never runs past P-1.
  assign last_cycle = (cnt_q == period - N'(1));

  // Phase FSM: disable wins, then restart/start, then phase flip at the end of a half-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DISABLED;
      cnt_q   <= '0;
      led_q   <= 1'b0;
    end else if (!en || period == '0) begin
      state_q <= DISABLED;
      cnt_q   <= '0;
      led_q   <= 1'b0;
    end else if (restart || state_q == DISABLED) begin
      state_q <= ON_PHASE;
      cnt_q   <= '0;
      led_q   <= 1'b1;
    end else if (last_cycle) begin
      cnt_q <= '0;
      if (state_q == ON_PHASE) begin
        state_q <= OFF_PHASE;
        led_q   <= 1'b0;
      end else begin
        state_q <= ON_PHASE;
        led_q   <= 1'b1;
      end
    end else begin
      cnt_q <= cnt_q + N'(1);
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// rtl/led_blink_ctrl.sv - MMIO register file and per-LED blink channels; BLINK_PHASE_SYNC_EN adds the phase-sync write
module led_blink_ctrl
  import blink_pkg::*;
#(
  parameter int NCH = 4,
  parameter int N   = 27
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cs,
  input  logic           read,
  input  logic           write,
  input  logic [4:0]     addr,
  input  logic [31:0]    wr_data,
  output logic [31:0]    rd_data,
  output logic [NCH-1:0] led
);

  logic [NCH-1:0] ctrl_q, ctrl_d;
  logic [NCH-1:0] restart_q, restart_d;
  logic [N-1:0]   period_q [NCH];
  logic [N-1:0]   period_d [NCH];
  logic           wr_en;
  logic           rd_en;
  logic           sync_wr;
  logic           unused_wr_bits;

  assign wr_en = cs & write;
  assign rd_en = cs & read;

  // Only low bits of wr_data land in registers; the rest is deliberately dropped.
  assign unused_wr_bits = ^wr_data;

`ifdef BLINK_PHASE_SYNC_EN
  assign sync_wr = wr_en && (addr == ADDR_SYNC);
`else
  assign sync_wr = 1'b0;
`endif

  // Register-file next state; a PERIOD write also arms a one-shot restart for that channel.
  always_comb begin
    ctrl_d    = ctrl_q;
    restart_d = '0;
    for (int k = 0; k < NCH; k++) begin
      period_d[k] = period_q[k];
    end
    if (wr_en) begin
      if (addr == ADDR_CTRL) begin
        ctrl_d = wr_data[NCH-1:0];
      end
      for (int k = 0; k < NCH; k++) begin
        if (addr == ADDR_PERIOD_BASE + 5'(k)) begin
          period_d[k]  = wr_data[N-1:0];
          restart_d[k] = 1'b1;
        end
      end
    end
  end

  // Register file state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      restart_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        period_q[k] <= '0;
      end
    end else begin
      ctrl_q    <= ctrl_d;
      restart_q <= restart_d;
      for (int k = 0; k < NCH; k++) begin
        period_q[k] <= period_d[k];
      end
    end
  end

  // Zero-latency read mux; SYNC is write-only and unmapped addresses read 0.
  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      if (addr == ADDR_CTRL) begin
        rd_data[NCH-1:0] = ctrl_q;
      end else if (addr == ADDR_SYNC) begin
        rd_data = '0;
      end
      for (int k = 0; k < NCH; k++) begin
        if (addr == ADDR_PERIOD_BASE + 5'(k)) begin
          rd_data[N-1:0] = period_q[k];
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    blink_channel #(
      .N(N)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (ctrl_q[g]),
      .period (period_q[g]),
      .restart(restart_q[g] | sync_wr),
      .led    (led[g])
    );
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb/tb_led_blink_ctrl.sv - table-driven self-checking bench for led_blink_ctrl
module tb_led_blink_ctrl;

  localparam int NCH = 4;
  localparam int N   = 27;

  logic           clk = 1'b0;
  logic           rst;
  logic           cs;
  logic           read;
  logic           write;
  logic [4:0]     addr;
  logic [31:0]    wr_data;
  logic [31:0]    rd_data;
  logic [NCH-1:0] led;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_blink_ctrl #(
    .NCH(NCH),
    .N  (N)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cs     (cs),
    .read   (read),
    .write  (write),
    .addr   (addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .led    (led)
  );

  typedef struct {
    logic        rst;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [3:0]  exp_led;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic c, input logic rd, input logic wr,
                     input logic [4:0] a, input logic [31:0] d, input logic [3:0] m,
                     input logic [3:0] e, input logic crd, input logic [31:0] erd);
    vec_t v;
    v.rst = r; v.cs = c; v.rd = rd; v.wr = wr; v.addr = a; v.data = d;
    v.mask = m; v.exp_led = e; v.chk_rd = crd; v.exp_rd = erd;
    tbl.push_back(v);
  endtask

  task automatic idle(input logic [3:0] m, input logic [3:0] e);
    add(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, m, e, 1'b0, 32'd0);
  endtask

  task automatic wrv(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m, input logic [3:0] e);
    add(1'b0, 1'b1, 1'b0, 1'b1, a, d, m, e, 1'b0, 32'd0);
  endtask

  task automatic rdv(input logic [4:0] a, input logic [31:0] erd, input logic [3:0] m, input logic [3:0] e);
    add(1'b0, 1'b1, 1'b1, 1'b0, a, 32'd0, m, e, 1'b1, erd);
  endtask

  task automatic rstv();
    add(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'hF, 4'h0, 1'b0, 32'd0);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst     = tbl[i].rst;
      cs      = tbl[i].cs;
      read    = tbl[i].rd;
      write   = tbl[i].wr;
      addr    = tbl[i].addr;
      wr_data = tbl[i].data;
      #1;
      if (tbl[i].chk_rd) begin
        n_vec++;
        if (rd_data !== tbl[i].exp_rd) begin
          n_bad++;
          $display("FAIL %s[%0d] rd_data addr=%0h got=%h want=%h", tag, i, tbl[i].addr, rd_data, tbl[i].exp_rd);
        end
      end
      @(posedge clk);
      #1;
      if (tbl[i].mask != 4'h0) begin
        n_vec++;
        if ((led & tbl[i].mask) !== (tbl[i].exp_led & tbl[i].mask)) begin
          n_bad++;
          $display("FAIL %s[%0d] led got=%b want=%b mask=%b", tag, i, led, tbl[i].exp_led, tbl[i].mask);
        end
      end
    end
    tbl.delete();
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;

    // Reset and idle state.
    rstv(); rstv();
    rdv(5'd0, 32'd0, 4'hF, 4'h0);
    for (int a = 1; a <= 4; a++) rdv(5'(a), 32'd0, 4'hF, 4'h0);
    for (int i = 0; i < 10; i++) idle(4'hF, 4'h0);

    // Channel 0, P=3: 3 high / 3 low; re-writing CTRL=1 mid-run changes nothing.
    wrv(5'd1, 32'd3, 4'hF, 4'h0);
    rdv(5'd1, 32'd3, 4'hF, 4'h0);
    wrv(5'd0, 32'd1, 4'hF, 4'h0);
    for (int k = 1; k <= 30; k++) begin
      if (k == 10) wrv(5'd0, 32'd1, 4'hF, (((k - 1) / 3) % 2 == 0) ? 4'h1 : 4'h0);
      else         idle(4'hF, (((k - 1) / 3) % 2 == 0) ? 4'h1 : 4'h0);
    end
    wrv(5'd0, 32'd0, 4'hF, 4'h1);
    for (int i = 0; i < 3; i++) idle(4'hF, 4'h0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 32'd0, 4'hF, 4'h0, 1'b1, 32'd0);

    // Channel 1, P=1: toggles every cycle; disable while on.
    wrv(5'd2, 32'd1, 4'hF, 4'h0);
    wrv(5'd0, 32'd2, 4'hF, 4'h0);
    for (int j = 1; j <= 7; j++) idle(4'hF, (j % 2 == 1) ? 4'h2 : 4'h0);
    wrv(5'd0, 32'd0, 4'hF, 4'h0);
    for (int i = 0; i < 4; i++) idle(4'hF, 4'h0);

    // Channel 2, P=5 then re-programmed to 2 during OFF at cnt=3.
    wrv(5'd3, 32'd5, 4'hF, 4'h0);
    wrv(5'd0, 32'd4, 4'hF, 4'h0);
    for (int m = 1; m <= 9; m++) idle(4'hF, (m <= 5) ? 4'h4 : 4'h0);
    wrv(5'd3, 32'd2, 4'hF, 4'h0);
    rdv(5'd3, 32'd2, 4'hF, 4'h4);
    for (int m = 12; m <= 18; m++) idle(4'hF, (((m - 11) / 2) % 2 == 0) ? 4'h4 : 4'h0);
    wrv(5'd0, 32'd0, 4'hF, 4'h4);
    for (int i = 0; i < 3; i++) idle(4'hF, 4'h0);

    // Field widths and unmapped addresses.
    wrv(5'd5, 32'hFFFF_FFFF, 4'hF, 4'h0);
    rdv(5'd5, 32'd0, 4'hF, 4'h0);
    wrv(5'd0, 32'hFFFF_FFF0, 4'hF, 4'h0);
    rdv(5'd0, 32'd0, 4'hF, 4'h0);
    wrv(5'd2, 32'hFFFF_FFFF, 4'hF, 4'h0);
    rdv(5'd2, 32'h07FF_FFFF, 4'hF, 4'h0);

    // Channel 3 enabled with P=0 stays off; P write starts it; reset mid-ON clears all.
    wrv(5'd0, 32'd8, 4'hF, 4'h0);
    for (int i = 0; i < 3; i++) idle(4'hF, 4'h0);
    wrv(5'd4, 32'd4, 4'hF, 4'h0);
    idle(4'hF, 4'h8);
    idle(4'hF, 4'h8);
    rstv();
    rdv(5'd0, 32'd0, 4'hF, 4'h0);
    rdv(5'd4, 32'd0, 4'hF, 4'h0);
    rdv(5'd2, 32'd0, 4'hF, 4'h0);
    for (int i = 0; i < 3; i++) idle(4'hF, 4'h0);
    run_table("main");

`ifdef BLINK_PHASE_SYNC_EN
    // Out-of-phase channels 0 (P=3) and 1 (P=5) realigned by a SYNC write.
    rstv();
    wrv(5'd1, 32'd3, 4'h0, 4'h0);
    wrv(5'd2, 32'd5, 4'h0, 4'h0);
    wrv(5'd0, 32'd1, 4'h0, 4'h0);
    idle(4'h0, 4'h0); idle(4'h0, 4'h0);
    wrv(5'd0, 32'd3, 4'h0, 4'h0);
    idle(4'h0, 4'h0); idle(4'h0, 4'h0); idle(4'h0, 4'h0);
    wrv(5'h1F, 32'h1234_5678, 4'hF, 4'h3);
    for (int i = 1; i <= 10; i++)
      idle(4'hF, {2'b00, ((i / 5) % 2 == 0), ((i / 3) % 2 == 0)});
    rdv(5'h1F, 32'd0, 4'h0, 4'h0);
    run_table("sync");
`else
    // Without the sync feature, a write to 0x1F leaves the running pattern untouched.
    rstv();
    wrv(5'd1, 32'd3, 4'hF, 4'h0);
    wrv(5'd0, 32'd1, 4'hF, 4'h0);
    for (int k = 1; k <= 4; k++) idle(4'hF, (k <= 3) ? 4'h1 : 4'h0);
    wrv(5'h1F, 32'hFFFF_FFFF, 4'hF, 4'h0);
    rdv(5'h1F, 32'd0, 4'hF, 4'h0);
    idle(4'hF, 4'h1);
    idle(4'hF, 4'h1);
    run_table("nosync");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
